// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_sched_pkg;

  localparam int AES_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KLOAD,
    ST_KWAIT,
    ST_TLOAD,
    ST_BUSY,
    ST_RESP
  } state_t;

  // Width of the shared wait/timeout counter. It must hold the larger limit
  // without wrapping, and it is never narrower than one bit.
  function automatic int cnt_width(input int key_wait, input int timeout);
    int m;
    m = (key_wait > timeout) ? key_wait : timeout;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after i_last, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
//
// Ports:
//   i_req  [N]          request vector
//   i_last [log2 N]     index of the previous winner (lowest priority)
//   o_gnt  [N]          one-hot grant, zero when no request
//   o_idx  [log2 N]     index of the granted requester
//   o_any               at least one request present
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int IW = $clog2(N);

  int w_best;

  // Priority distance of requester j is (j - last - 1) mod N; the smallest
  // distance among active requesters wins, so i_last itself comes last.
  always_comb begin
    w_best = N;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (i_req[j] && (((j + N - 1 - int'(i_last)) % N) < w_best)) begin
        w_best = (j + N - 1 - int'(i_last)) % N;
        o_idx  = IW'(j);
        o_any  = 1'b1;
      end
    end
  end

  assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/aes_job_sched.sv
// Shares one AES core between NREQ requesters: round-robin accept, kld/ld sequencing, done/timeout, response return.
// Latency: miss accept T -> kld T+1, ld T+2+KEY_WAIT; hit accept T -> ld T+1; done D -> rsp_valid D+1.
// Backpressure: one job in flight; no new accept until the owner takes the response with rsp_ready_i.
//
// Ports:
//   wb_clk_i, wb_rst_i                     clock, synchronous active-high reset
//   req_valid_i/req_ready_o/req_key_i/req_text_i/req_mode_i   per-requester job inputs, one-hot accept
//   rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_err_o              one-hot result return, shared data bus
//   aes_kld_o/aes_ld_o/aes_key_o/aes_text_o/aes_mode_o        strobes and latched operands to the core
//   aes_done_i/aes_text_i                  core completion and result
//   busy_o, owner_o                        job in progress, current owner index
module aes_job_sched
  import aes_sched_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int KEY_WAIT = 12,
  parameter int TIMEOUT  = 64
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*AES_W-1:0]   req_key_i,
  input  logic [NREQ*AES_W-1:0]   req_text_i,
  input  logic [NREQ-1:0]         req_mode_i,
  output logic [NREQ-1:0]         rsp_valid_o,
  input  logic [NREQ-1:0]         rsp_ready_i,
  output logic [AES_W-1:0]        rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    aes_kld_o,
  output logic                    aes_ld_o,
  output logic [AES_W-1:0]        aes_key_o,
  output logic [AES_W-1:0]        aes_text_o,
  output logic                    aes_mode_o,
  input  logic                    aes_done_i,
  input  logic [AES_W-1:0]        aes_text_i,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] owner_o
);

  localparam int OW = $clog2(NREQ);
  localparam int SW = $clog2(NREQ * AES_W);
  localparam int CW = cnt_width(KEY_WAIT, TIMEOUT);
  localparam logic [CW-1:0] KW_LAST = CW'((KEY_WAIT > 0) ? KEY_WAIT - 1 : 0);
  localparam logic [CW-1:0] TO_CNT  = CW'(TIMEOUT);

  state_t            r_state, w_next;
  logic [OW-1:0]     r_last, r_owner;
  logic [AES_W-1:0]  r_key, r_text, r_rsp_data, r_cache_key;
  logic              r_mode, r_rsp_err, r_cache_vld, r_cache_mode;
  logic [CW-1:0]     r_cnt;

  logic [NREQ-1:0]   w_gnt, w_own_oh;
  logic [OW-1:0]     w_gnt_idx;
  logic              w_any, w_accept, w_hit, w_timeout, w_sel_mode;
  logic [SW-1:0]     w_sel_base;
  logic [AES_W-1:0]  w_sel_key, w_sel_text;

  rr_arbiter #(.N(NREQ)) u_arb (
    .i_req  (req_valid_i),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx),
    .o_any  (w_any)
  );

  assign w_sel_base = {w_gnt_idx, {$clog2(AES_W){1'b0}}};
  assign w_sel_key  = req_key_i[w_sel_base +: AES_W];
  assign w_sel_text = req_text_i[w_sel_base +: AES_W];
  assign w_sel_mode = req_mode_i[w_gnt_idx];

  // A cached key is only reusable for the same direction: the core expands
  // the schedule differently for decrypt.
  assign w_hit     = r_cache_vld && (r_cache_key == w_sel_key) && (r_cache_mode == w_sel_mode);
  assign w_accept  = (r_state == ST_IDLE) && w_any;
  assign w_timeout = (r_cnt >= TO_CNT);
  assign w_own_oh  = NREQ'(1) << r_owner;

  always_comb begin
    w_next      = r_state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    aes_kld_o   = 1'b0;
    aes_ld_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready_o = w_gnt;
          w_next      = w_hit ? ST_TLOAD : ST_KLOAD;
        end
      end
      ST_KLOAD: begin
        aes_kld_o = 1'b1;
        w_next    = (KEY_WAIT == 0) ? ST_TLOAD : ST_KWAIT;
      end
      ST_KWAIT: if (r_cnt >= KW_LAST) w_next = ST_TLOAD;
      ST_TLOAD: begin
        aes_ld_o = 1'b1;
        w_next   = ST_BUSY;
      end
      ST_BUSY:  if (aes_done_i || w_timeout) w_next = ST_RESP;
      ST_RESP: begin
        rsp_valid_o = w_own_oh;
        if (rsp_ready_i[r_owner]) w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
    // Reset aborts at once: nothing leaves the block during the reset cycle.
    if (wb_rst_i) begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      aes_kld_o   = 1'b0;
      aes_ld_o    = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_last       <= OW'(NREQ - 1);
      r_owner      <= '0;
      r_key        <= '0;
      r_text       <= '0;
      r_mode       <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_cache_vld  <= 1'b0;
      r_cache_key  <= '0;
      r_cache_mode <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_key   <= w_sel_key;
        r_text  <= w_sel_text;
        r_mode  <= w_sel_mode;
        r_owner <= w_gnt_idx;
      end
      case (r_state)
        ST_KLOAD: begin
          r_cache_key  <= r_key;
          r_cache_mode <= r_mode;
          r_cache_vld  <= 1'b1;
          r_cnt        <= '0;
        end
        ST_TLOAD:          r_cnt <= '0;
        ST_KWAIT, ST_BUSY: if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
      if (r_state == ST_BUSY) begin
        if (aes_done_i) begin
          r_rsp_data <= aes_text_i;
          r_rsp_err  <= 1'b0;
        end else if (w_timeout) begin
          // The core state is unknown after a hang, so the loaded key is not trusted.
          r_rsp_data  <= '0;
          r_rsp_err   <= 1'b1;
          r_cache_vld <= 1'b0;
        end
      end
      if ((r_state == ST_RESP) && rsp_ready_i[r_owner]) r_last <= r_owner;
    end
  end

  assign rsp_data_o = r_rsp_data;
  assign rsp_err_o  = r_rsp_err;
  assign aes_key_o  = r_key;
  assign aes_text_o = r_text;
  assign aes_mode_o = r_mode;
  assign busy_o     = (r_state != ST_IDLE);
  assign owner_o    = r_owner;

endmodule

// File: tb/tb_aes_job_sched.sv
// Directed bench for aes_job_sched with a behavioural AES core and a response scoreboard.
// Latency: the core model raises done 10 cycles after ld unless disabled.
// Backpressure: rsp_ready_i is normally high; one step holds it low.
module tb_aes_job_sched;

  localparam int NREQ = 2, KEY_WAIT = 12, TIMEOUT = 64;
  localparam logic [127:0] KV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TV = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RV = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] T1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i = 1'b1;
  logic [NREQ-1:0]     req_valid_i = '0;
  logic [NREQ-1:0]     req_ready_o;
  logic [NREQ*128-1:0] req_key_i = '0;
  logic [NREQ*128-1:0] req_text_i = '0;
  logic [NREQ-1:0]     req_mode_i = '0;
  logic [NREQ-1:0]     rsp_valid_o;
  logic [NREQ-1:0]     rsp_ready_i = '1;
  logic [127:0]        rsp_data_o;
  logic                rsp_err_o;
  logic                aes_kld_o, aes_ld_o, aes_mode_o, busy_o;
  logic [127:0]        aes_key_o, aes_text_o;
  logic                aes_done_i = 1'b0;
  logic [127:0]        aes_text_i = '0;
  logic [0:0]          owner_o;

  aes_job_sched #(.NREQ(NREQ), .KEY_WAIT(KEY_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_key_i(req_key_i),
    .req_text_i(req_text_i), .req_mode_i(req_mode_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .aes_kld_o(aes_kld_o), .aes_ld_o(aes_ld_o),
    .aes_key_o(aes_key_o), .aes_text_o(aes_text_o), .aes_mode_o(aes_mode_o),
    .aes_done_i(aes_done_i), .aes_text_i(aes_text_i), .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  typedef struct {
    int           owner;
    logic [127:0] data;
    logic         err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference core: the published vector, otherwise an arbitrary mix of operands.
  function automatic logic [127:0] f_res(input logic [127:0] k, input logic [127:0] t, input logic m);
    if (k == KV && t == TV && m) return RV;
    return k ^ {t[63:0], t[127:64]} ^ {128{m}};
  endfunction

  // Core model: done fires in the 10th cycle after the ld cycle.
  int cd = 0;
  bit model_en = 1'b1;
  bit spur_done = 1'b0;
  always @(negedge wb_clk_i) begin : core_model
    #2;
    aes_done_i = spur_done;
    if (wb_rst_i) cd = 0;
    else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          aes_done_i = 1'b1;
          aes_text_i = f_res(aes_key_o, aes_text_o, aes_mode_o);
        end
      end
      if (aes_ld_o && model_en) cd = 10;
    end
  end

  // Event recorder and scoreboard consumer.
  int acc_cnt = 0, acc_cyc = 0, kld_cnt = 0, kld_cyc = 0, ld_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
  int grant_log[$];
  always @(negedge wb_clk_i) begin : monitor
    exp_t e;
    logic [NREQ-1:0] ev;
    #3;
    if (!wb_rst_i) begin
      if ((req_ready_o & req_valid_i) != '0) begin
        acc_cnt++;
        acc_cyc = cyc;
        grant_log.push_back(req_ready_o[1] ? 1 : 0);
      end
      if (aes_kld_o) begin kld_cnt++; kld_cyc = cyc; end
      if (aes_ld_o) ld_cyc = cyc;
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        if (sb.size() == 0) chk("unexpected_rsp", 128'(rsp_valid_o), 128'd0);
        else begin
          e = sb.pop_front();
          ev = '0;
          ev[e.owner] = 1'b1;
          chk("rsp_valid", 128'(rsp_valid_o), 128'(ev));
          chk("rsp_owner", 128'(owner_o), 128'(e.owner));
          chk("rsp_data", rsp_data_o, e.data);
          chk("rsp_err", 128'(rsp_err_o), 128'(e.err));
        end
      end
    end
  end

  task automatic nxt();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic set_req(input int r, input logic [127:0] k, input logic [127:0] t, input logic m);
    req_key_i[128*r +: 128]  = k;
    req_text_i[128*r +: 128] = t;
    req_mode_i[r]            = m;
  endtask

  task automatic push_exp(input int r, input logic [127:0] k, input logic [127:0] t, input logic m, input bit to);
    exp_t e;
    e.owner = r;
    e.data  = to ? 128'd0 : f_res(k, t, m);
    e.err   = to;
    sb.push_back(e);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int i = 0;
    while (acc_cnt < target && i < budget) begin nxt(); i++; end
    chk("wait_accept", 128'(acc_cnt), 128'(target));
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int i = 0;
    while (rsp_cnt < target && i < budget) begin nxt(); i++; end
    chk("wait_response", 128'(rsp_cnt), 128'(target));
  endtask

  task automatic run_job(input int r, input logic [127:0] k, input logic [127:0] t, input logic m,
                         input bit to, output int t_acc);
    int a0, r0;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    push_exp(r, k, t, m, to);
    set_req(r, k, t, m);
    req_valid_i[r] = 1'b1;
    wait_acc(a0 + 1, 50);
    req_valid_i[r] = 1'b0;
    t_acc = acc_cyc;
    wait_rsp(r0 + 1, 200);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, kc, g0, a0, r0, i;
    logic [127:0] hold_exp;

    wb_rst_i = 1'b1;
    repeat (3) nxt();
    wb_rst_i = 1'b0;
    nxt();
    chk("rst_req_ready", 128'(req_ready_o), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_kld", 128'(aes_kld_o), 128'd0);
    chk("rst_ld", 128'(aes_ld_o), 128'd0);
    chk("rst_aes_key", aes_key_o, 128'd0);
    chk("rst_aes_text", aes_text_o, 128'd0);
    chk("rst_aes_mode", 128'(aes_mode_o), 128'd0);
    chk("rst_rsp_data", rsp_data_o, 128'd0);
    chk("rst_rsp_err", 128'(rsp_err_o), 128'd0);
    chk("rst_owner", 128'(owner_o), 128'd0);

    // Known-answer job: cold cache, full key wait.
    kc = kld_cnt;
    run_job(0, KV, TV, 1'b1, 1'b0, t);
    chk("kat_kld_count", 128'(kld_cnt), 128'(kc + 1));
    chk("kat_kld_time", 128'(kld_cyc), 128'(t + 1));
    chk("kat_ld_time", 128'(ld_cyc), 128'(t + 2 + KEY_WAIT));
    chk("kat_rsp_time", 128'(rsp_cyc), 128'(ld_cyc + 11));

    // Same key and mode: cache hit.
    kc = kld_cnt;
    run_job(0, KV, TV, 1'b1, 1'b0, t);
    chk("hit_no_kld", 128'(kld_cnt), 128'(kc));
    chk("hit_ld_time", 128'(ld_cyc), 128'(t + 1));
    chk("hit_rsp_time", 128'(rsp_cyc), 128'(ld_cyc + 11));

    // Same key, decrypt: miss.
    kc = kld_cnt;
    run_job(0, KV, TV, 1'b0, 1'b0, t);
    chk("mode_kld_count", 128'(kld_cnt), 128'(kc + 1));
    chk("mode_kld_time", 128'(kld_cyc), 128'(t + 1));
    chk("mode_ld_time", 128'(ld_cyc), 128'(t + 2 + KEY_WAIT));

    // Core never answers: error response, cache dropped.
    model_en = 1'b0;
    kc = kld_cnt;
    run_job(0, KV, TV, 1'b0, 1'b1, t);
    model_en = 1'b1;
    chk("to_hit_no_kld", 128'(kld_cnt), 128'(kc));
    chk("to_ld_time", 128'(ld_cyc), 128'(t + 1));
    chk("to_rsp_time", 128'(rsp_cyc), 128'(ld_cyc + TIMEOUT + 2));
    kc = kld_cnt;
    run_job(1, KV, TV, 1'b0, 1'b0, t);
    chk("after_to_kld_count", 128'(kld_cnt), 128'(kc + 1));
    chk("after_to_kld_time", 128'(kld_cyc), 128'(t + 1));

    // Both requesters continuously valid: grants alternate starting with 0.
    set_req(0, KV, TV, 1'b1);
    set_req(1, K1, T1, 1'b0);
    push_exp(0, KV, TV, 1'b1, 1'b0);
    push_exp(1, K1, T1, 1'b0, 1'b0);
    push_exp(0, KV, TV, 1'b1, 1'b0);
    push_exp(1, K1, T1, 1'b0, 1'b0);
    g0 = grant_log.size();
    a0 = acc_cnt;
    r0 = rsp_cnt;
    req_valid_i = 2'b11;
    wait_acc(a0 + 4, 400);
    req_valid_i = 2'b00;
    wait_rsp(r0 + 4, 400);
    chk("alt_grant_count", 128'(grant_log.size()), 128'(g0 + 4));
    for (int k = 0; k < 4; k++)
      if (g0 + k < grant_log.size()) chk("alt_grant_order", 128'(grant_log[g0 + k]), 128'(k % 2));

    // Response held off for 5 cycles while the other requester waits.
    rsp_ready_i = 2'b00;
    hold_exp = f_res(K1, TV, 1'b1);
    push_exp(0, K1, TV, 1'b1, 1'b0);
    set_req(0, K1, TV, 1'b1);
    a0 = acc_cnt;
    r0 = rsp_cnt;
    req_valid_i[0] = 1'b1;
    wait_acc(a0 + 1, 50);
    req_valid_i[0] = 1'b0;
    i = 0;
    while (rsp_valid_o == '0 && i < 100) begin nxt(); i++; end
    chk("hold_rsp_seen", 128'(rsp_valid_o), 128'd1);
    set_req(1, KV, TV, 1'b1);
    req_valid_i[1] = 1'b1;
    repeat (5) begin
      nxt();
      chk("hold_rsp_valid", 128'(rsp_valid_o), 128'd1);
      chk("hold_rsp_data", rsp_data_o, hold_exp);
      chk("hold_no_grant", 128'(req_ready_o), 128'd0);
    end
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b11;
    wait_rsp(r0 + 1, 10);

    // Reset while BUSY: job dropped silently, late done ignored.
    model_en = 1'b0;
    set_req(0, KV, TV, 1'b1);
    a0 = acc_cnt;
    r0 = rsp_cnt;
    req_valid_i[0] = 1'b1;
    wait_acc(a0 + 1, 50);
    req_valid_i[0] = 1'b0;
    repeat (20) nxt();
    chk("midrst_busy_before", 128'(busy_o), 128'd1);
    wb_rst_i = 1'b1;
    nxt();
    wb_rst_i = 1'b0;
    spur_done = 1'b1;
    chk("midrst_busy", 128'(busy_o), 128'd0);
    chk("midrst_rsp_valid", 128'(rsp_valid_o), 128'd0);
    nxt();
    spur_done = 1'b0;
    chk("midrst_busy_after_done", 128'(busy_o), 128'd0);
    chk("midrst_rsp_after_done", 128'(rsp_valid_o), 128'd0);
    repeat (3) nxt();
    chk("midrst_no_rsp", 128'(rsp_cnt), 128'(r0));
    model_en = 1'b1;

    // Reset also clears the key cache.
    kc = kld_cnt;
    run_job(0, KV, TV, 1'b1, 1'b0, t);
    chk("postrst_kld_count", 128'(kld_cnt), 128'(kc + 1));
    chk("postrst_kld_time", 128'(kld_cyc), 128'(t + 1));

    repeat (2) nxt();
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_job_sched.md
# aes_job_sched

Round-robin job scheduler that shares a single AES core between NREQ requesters. It accepts one 128-bit key/text/mode job at a time and sequences the core's key-load (kld) and text-load (ld) strobes. It waits for done, with a timeout, and returns the result to the owning requester. It sits between the Wishbone-facing register banks and the AES datapath, and replaces direct register-driven ld/kld.

## Interface
- NREQ, 2: number of requesters (2..8).
- KEY_WAIT, 12: cycles to wait after kld before ld; 0 skips the wait state.
- TIMEOUT, 64: maximum BUSY cycles before the job is aborted with an error.
- Clocking (already decided): one clock, `wb_clk_i`. Reset `wb_rst_i` is synchronous and active-high.
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NREQ  job request per requester
- req_ready_o  out  NREQ  one-hot grant/accept
- req_key_i  in  NREQ*128  key, requester i at [128*i +: 128]
- req_text_i  in  NREQ*128  plaintext/ciphertext
- req_mode_i  in  NREQ  1 = encrypt, 0 = decrypt
- rsp_valid_o  out  NREQ  one-hot result valid
- rsp_ready_i  in  NREQ  result accept
- rsp_data_o  out  128  result, shared bus
- rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o
- aes_kld_o / aes_ld_o  out  1  one-cycle strobes to the core
- aes_key_o / aes_text_o  out  128  latched job operands
- aes_mode_o  out  1  latched mode
- aes_done_i  in  1  core completion
- aes_text_i  in  128  core result
- busy_o  out  1  state != IDLE
- owner_o  out  $clog2(NREQ)  index of the current job owner

## Operation
- FSM states: IDLE, KLOAD, KWAIT, TLOAD, BUSY, RESP.
- IDLE: the round-robin arbiter selects the first valid requester after `last_owner`. req_ready_o is asserted combinationally for that requester only.
  - The handshake (valid & ready) latches key, text, mode and owner.
  - On a key-cache hit (cache valid, key equal, mode equal) the FSM goes to TLOAD. Otherwise it goes to KLOAD.
- KLOAD: aes_kld_o = 1 for one cycle; the cache key/mode are updated and marked valid. Next state is KWAIT, or TLOAD if KEY_WAIT = 0.
- KWAIT: a counter runs KEY_WAIT cycles, then the FSM goes to TLOAD.
- TLOAD: aes_ld_o = 1 for one cycle; the BUSY counter is cleared. Next state is BUSY.
- BUSY:
  - On aes_done_i, latch aes_text_i into rsp_data, set err = 0, go to RESP.
  - Else, when the counter reaches TIMEOUT, set rsp_data = 0, err = 1, invalidate the key cache, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP: rsp_valid_o[owner] is held until rsp_ready_i[owner]. Then last_owner = owner and the FSM returns to IDLE.
- aes_done_i is ignored outside BUSY.
- req_valid_i may drop before a grant with no effect. A requester is never granted twice in a row while another requester is valid.

## Timing
- Reset values:
  - State IDLE; last_owner = NREQ-1, so requester 0 has first priority.
  - Key cache invalid.
  - All outputs 0, including aes_key_o, aes_text_o and rsp_data_o.
- Reset mid-job aborts immediately. No response is issued and no strobe is emitted in the reset cycle.
- Cache miss, accept at cycle T:
  - kld at T+1; ld at T+2+KEY_WAIT; BUSY from T+3+KEY_WAIT.
- Cache hit, accept at T: ld at T+1, BUSY from T+2.
- aes_done_i at cycle D gives rsp_valid_o at D+1.
- The earliest next accept is the cycle after the rsp handshake.
- Timeout: err response at TLOAD + 1 + TIMEOUT + 1 when no done arrives.
- aes_key_o, aes_text_o and aes_mode_o are stable from the cycle after accept until the next accept.
- Counters are $clog2(max(KEY_WAIT, TIMEOUT)+1) bits wide and saturate; they never wrap.

## Structure
- Package `aes_sched_pkg`: state enum, the AES_W = 128 constant, and the counter-width function.
- Sub-module `rr_arbiter`:
  - Parameter N.
  - Inputs: req, last index.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational.
- The top module holds the FSM, operand registers, key cache and counters.

## Test plan
- NREQ = 2, KEY_WAIT = 12. Requester 0 sends key 000102..0f, text 00112233..eeff, encrypt. Model done 10 cycles after ld with result 69c4e0d8..c55a.
  - Required: kld at T+1, ld at T+14, rsp_valid_o = 2'b01, rsp_data_o = 69c4e0d8..c55a, err 0.
- Requester 0 repeats the same key and mode.
  - Required: no kld; ld at T+1.
- Same key but mode = 0: this is a cache miss, so kld is issued.
- Both requesters valid continuously.
  - Required: grants alternate 0, 1, 0, 1. owner_o matches each grant.
- No done from the model.
  - Required: rsp_err_o = 1 and rsp_data_o = 0 exactly TIMEOUT+2 cycles after ld.
  - The next job with the same key issues kld, because the cache was invalidated.
- Assert wb_rst_i during BUSY.
  - Required: next cycle busy_o = 0, rsp_valid_o = 0, and a spurious aes_done_i is ignored.
- Hold rsp_ready_i low for 5 cycles.
  - Required: rsp_valid_o and rsp_data_o stay stable, and no new grant is issued.
